// File: rtl/bm_drd_port.sv
// bm_drd_port: responder/arbiter end of the drd_* burst-read protocol.
// One requester is granted and sends a two-word command (header, byte
// address). The block then issues a single read burst on the memory read
// channel and forwards each returned beat to the requester one cycle later.
// Header layout: {22'b0, last, rd, len_m1[7:0]}.
module bm_drd_port #(
   parameter int GAP_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enb,
   input  logic        drd_req,
   output logic        drd_ack,
   input  logic        drd_cvin,
   input  logic [31:0] drd_cdin,
   output logic        drd_vout,
   output logic [31:0] drd_dout,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   output logic [31:0] mem_araddr,
   output logic [7:0]  mem_arlen,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rlast,
   output logic        frm_done,
   output logic        err,
   input  logic        err_clr
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_ADR  = 3'd2,
      ST_AR   = 3'd3,
      ST_DATA = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

   state_t      state_q;
   logic        drd_ack_q;
   logic        drd_vout_q;
   logic [31:0] drd_dout_q;
   logic        mem_arvalid_q;
   logic [31:0] mem_araddr_q;
   logic [7:0]  mem_arlen_q;
   logic        frm_done_q;
   logic        frm_pend_q;
   logic [7:0]  len_q;
   logic        last_q;
   logic [7:0]  beat_q;
   logic [15:0] gap_q;
   logic        err_q;
   logic        err_d;

   // Sticky error next-state: protocol violations set it, err_clr clears it,
   // and a violation in the same cycle as err_clr keeps it set.
   always_comb begin
      err_d = err_q & ~err_clr;
      if (enb) begin
         case (state_q)
            ST_HDR: begin
               if (!drd_cvin || !drd_cdin[8]) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q & ~err_clr;
               end
            end
            ST_ADR: begin
               if (!drd_cvin) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q & ~err_clr;
               end
            end
            ST_DATA: begin
               // rlast must coincide exactly with beat index len_m1
               if (mem_rvalid && (mem_rlast != (beat_q == len_q))) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q & ~err_clr;
               end
            end
            default: begin
               err_d = err_q & ~err_clr;
            end
         endcase
      end else begin
         err_d = err_q & ~err_clr;
      end
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   // Grant / command / burst FSM with all requester and memory outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         drd_ack_q     <= 1'b0;
         drd_vout_q    <= 1'b0;
         drd_dout_q    <= 32'd0;
         mem_arvalid_q <= 1'b0;
         mem_araddr_q  <= 32'd0;
         mem_arlen_q   <= 8'd0;
         frm_done_q    <= 1'b0;
         frm_pend_q    <= 1'b0;
         len_q         <= 8'd0;
         last_q        <= 1'b0;
         beat_q        <= 8'd0;
         gap_q         <= 16'd0;
      end else if (!enb) begin
         // Disabled: abandon any burst; late memory beats are dropped.
         state_q       <= ST_IDLE;
         drd_ack_q     <= 1'b0;
         drd_vout_q    <= 1'b0;
         drd_dout_q    <= 32'd0;
         mem_arvalid_q <= 1'b0;
         frm_done_q    <= 1'b0;
         frm_pend_q    <= 1'b0;
      end else begin
         drd_ack_q  <= 1'b0;
         drd_vout_q <= 1'b0;
         drd_dout_q <= 32'd0;
         frm_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (drd_req) begin
                  drd_ack_q <= 1'b1;
                  state_q   <= ST_HDR;
               end
            end
            ST_HDR: begin
               // Header arrives in the ack cycle; a non-read header aborts.
               if (drd_cvin && drd_cdin[8]) begin
                  len_q   <= drd_cdin[7:0];
                  last_q  <= drd_cdin[9];
                  state_q <= ST_ADR;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ADR: begin
               if (drd_cvin) begin
                  mem_araddr_q  <= drd_cdin;
                  mem_arlen_q   <= len_q;
                  mem_arvalid_q <= 1'b1;
                  state_q       <= ST_AR;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_AR: begin
               if (mem_arready) begin
                  mem_arvalid_q <= 1'b0;
                  beat_q        <= 8'd0;
                  state_q       <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (mem_rvalid) begin
                  drd_vout_q <= 1'b1;
                  drd_dout_q <= mem_rdata;
                  beat_q     <= beat_q + 8'd1;
                  // Burst ends on whichever comes first: expected count or rlast.
                  if (mem_rlast || (beat_q == len_q)) begin
                     frm_pend_q <= last_q;
                     gap_q      <= 16'(GAP_CYC - 1);
                     state_q    <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               // First gap cycle follows the final drd_vout, so frm_done lands right after it.
               frm_done_q <= frm_pend_q;
               frm_pend_q <= 1'b0;
               if (gap_q == 16'd0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q - 16'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign drd_ack     = drd_ack_q;
   assign drd_vout    = drd_vout_q;
   assign drd_dout    = drd_dout_q;
   assign mem_arvalid = mem_arvalid_q;
   assign mem_araddr  = mem_araddr_q;
   assign mem_arlen   = mem_arlen_q;
   assign frm_done    = frm_done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_bm_drd_port.sv
// Directed self-checking bench for bm_drd_port (GAP_CYC = 2).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_bm_drd_port;

   logic        clk = 1'b0;
   logic        rst, enb, drd_req, drd_cvin, mem_arready, mem_rvalid, mem_rlast, err_clr;
   logic [31:0] drd_cdin, mem_rdata;
   logic        drd_ack, drd_vout, mem_arvalid, frm_done, err;
   logic [31:0] drd_dout, mem_araddr;
   logic [7:0]  mem_arlen;

   int errors = 0;
   int checks = 0;

   bm_drd_port #(.GAP_CYC(2)) dut (
      .clk(clk), .rst(rst), .enb(enb),
      .drd_req(drd_req), .drd_ack(drd_ack), .drd_cvin(drd_cvin), .drd_cdin(drd_cdin),
      .drd_vout(drd_vout), .drd_dout(drd_dout),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
      .mem_arlen(mem_arlen), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_rlast(mem_rlast), .frm_done(frm_done), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise drd_req, wait (bounded) for drd_ack, then send header and address.
   // waited = cycles until ack was seen, 255 on timeout (no command sent).
   task automatic grant(input logic [31:0] hdr, input logic [31:0] addr, output int waited);
      waited  = 255;
      drd_req = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (drd_ack === 1'b1) begin
            waited = n;
            break;
         end
      end
      if (waited != 255) begin
         drd_cvin = 1'b1;
         drd_cdin = hdr;
         tick();
         drd_cdin = addr;
         tick();
         drd_cvin = 1'b0;
         drd_cdin = 32'd0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enb = 1'b1; drd_req = 1'b0; drd_cvin = 1'b0; drd_cdin = 32'd0;
      mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'd0; err_clr = 1'b0;
      tick(); tick();
      checks++;
      if ({drd_ack, drd_vout, mem_arvalid, frm_done, err} !== 5'b00000) begin
         errors++; $display("FAIL reset_flags: got %b, expected 00000", {drd_ack, drd_vout, mem_arvalid, frm_done, err});
      end
      checks++;
      if (drd_dout !== 32'd0) begin errors++; $display("FAIL reset_dout: got %h, expected 0", drd_dout); end
      checks++;
      if (mem_araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr: got %h, expected 0", mem_araddr); end
      checks++;
      if (mem_arlen !== 8'd0) begin errors++; $display("FAIL reset_arlen: got %h, expected 0", mem_arlen); end
      rst = 1'b0;
      tick();
      checks++;
      if (drd_ack !== 1'b0) begin errors++; $display("FAIL reset_noreq_ack: got %b, expected 0", drd_ack); end
   endtask

   task automatic test_long_burst();
      int w;
      logic [31:0] exp;
      grant(32'h0000_013F, 32'h1234_0800, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL long_grant: waited %0d, expected 1", w); end
      checks++;
      if ({mem_arvalid, mem_araddr, mem_arlen} !== {1'b1, 32'h1234_0800, 8'h3F}) begin
         errors++; $display("FAIL long_ar: got v=%b a=%h l=%h, expected v=1 a=12340800 l=3f", mem_arvalid, mem_araddr, mem_arlen);
      end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      checks++;
      if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL long_ar_drop: got %b, expected 0", mem_arvalid); end
      for (int i = 0; i < 64; i++) begin
         exp = 32'hA500_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = (i == 63);
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp) begin
            errors++; $display("FAIL long_beat%0d: got v=%b d=%h, expected v=1 d=%h", i, drd_vout, drd_dout, exp);
         end
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'd0; drd_req = 1'b0;
      tick();
      checks++;
      if ({drd_vout, drd_dout, frm_done} !== {1'b0, 32'd0, 1'b0}) begin
         errors++; $display("FAIL long_after: got v=%b d=%h fd=%b, expected 0/0/0", drd_vout, drd_dout, frm_done);
      end
      tick();
      checks++;
      if (frm_done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL long_nofd: got fd=%b err=%b, expected 0/0", frm_done, err);
      end
      tick(); tick(); tick();
   endtask

   task automatic test_frame_gaps();
      int w;
      int gaps[8] = '{0, 2, 1, 0, 3, 0, 1, 2};
      logic [31:0] exp;
      grant(32'h0000_0307, 32'h0000_4000, w);
      checks++;
      if (w !== 1 || mem_arlen !== 8'h07) begin
         errors++; $display("FAIL frm_grant: waited %0d arlen=%h, expected 1 and 07", w, mem_arlen);
      end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
            tick();
            checks++;
            if (drd_vout !== 1'b0 || drd_dout !== 32'd0) begin
               errors++; $display("FAIL frm_gap%0d: got v=%b d=%h, expected 0/0", i, drd_vout, drd_dout);
            end
         end
         exp = 32'hC0DE_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = (i == 7);
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp || frm_done !== 1'b0) begin
            errors++; $display("FAIL frm_beat%0d: got v=%b d=%h fd=%b, expected 1/%h/0", i, drd_vout, drd_dout, frm_done, exp);
         end
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'd0; drd_req = 1'b0;
      tick();
      checks++;
      if (frm_done !== 1'b1) begin errors++; $display("FAIL frm_done_pulse: got %b, expected 1", frm_done); end
      tick();
      checks++;
      if (frm_done !== 1'b0) begin errors++; $display("FAIL frm_done_width: got %b, expected 0", frm_done); end
      tick(); tick();
   endtask

   task automatic test_arready_stall();
      int w;
      logic [31:0] exp;
      grant(32'h0000_0103, 32'h0000_1000, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL stall_grant: waited %0d, expected 1", w); end
      for (int c = 0; c < 10; c++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
         tick();
         checks++;
         if ({mem_arvalid, mem_araddr, mem_arlen, drd_vout} !== {1'b1, 32'h0000_1000, 8'h03, 1'b0}) begin
            errors++; $display("FAIL stall_c%0d: got v=%b a=%h l=%h dv=%b, expected 1/00001000/03/0", c, mem_arvalid, mem_araddr, mem_arlen, drd_vout);
         end
      end
      mem_rvalid = 1'b0;
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp = 32'h5500_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = (i == 3);
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp) begin
            errors++; $display("FAIL stall_beat%0d: got v=%b d=%h, expected 1/%h", i, drd_vout, drd_dout, exp);
         end
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0; drd_req = 1'b0;
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL stall_err: got %b, expected 0", err); end
      tick(); tick(); tick();
   endtask

   task automatic test_bad_header();
      drd_req = 1'b1;
      tick();
      checks++;
      if (drd_ack !== 1'b1) begin errors++; $display("FAIL badhdr_ack: got %b, expected 1", drd_ack); end
      drd_cvin = 1'b1; drd_cdin = 32'h0000_0007; drd_req = 1'b0;
      tick();
      drd_cvin = 1'b0; drd_cdin = 32'd0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL badhdr_err: got %b, expected 1", err); end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({mem_arvalid, drd_ack, err} !== 3'b001) begin
            errors++; $display("FAIL badhdr_idle%0d: got arv=%b ack=%b err=%b, expected 0/0/1", c, mem_arvalid, drd_ack, err);
         end
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL badhdr_clr: got %b, expected 0", err); end
      // New violation coinciding with err_clr must win.
      drd_req = 1'b1;
      tick();
      drd_cvin = 1'b1; drd_cdin = 32'h0000_0007; drd_req = 1'b0; err_clr = 1'b1;
      tick();
      drd_cvin = 1'b0; drd_cdin = 32'd0; err_clr = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL badhdr_clr_race: got %b, expected 1", err); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL badhdr_clr2: got %b, expected 0", err); end
      tick();
   endtask

   task automatic test_early_rlast();
      int w;
      logic [31:0] exp;
      grant(32'h0000_0107, 32'h0000_2000, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL early_grant: waited %0d, expected 1", w); end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp = 32'h7700_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = (i == 3);
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp) begin
            errors++; $display("FAIL early_beat%0d: got v=%b d=%h, expected 1/%h", i, drd_vout, drd_dout, exp);
         end
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL early_err: got %b, expected 1", err); end
      // req held: next grant only after the two gap cycles.
      grant(32'h0000_0100, 32'h0000_3000, w);
      checks++;
      if (w !== 3) begin errors++; $display("FAIL early_regrant: waited %0d, expected 3", w); end
      checks++;
      if (mem_arvalid !== 1'b1 || mem_arlen !== 8'h00 || mem_araddr !== 32'h0000_3000) begin
         errors++; $display("FAIL early_ar2: got v=%b l=%h a=%h, expected 1/00/00003000", mem_arvalid, mem_arlen, mem_araddr);
      end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h3333_0000; mem_rlast = 1'b1;
      tick();
      mem_rvalid = 1'b0; mem_rlast = 1'b0; drd_req = 1'b0;
      checks++;
      if (drd_vout !== 1'b1 || drd_dout !== 32'h3333_0000 || err !== 1'b1) begin
         errors++; $display("FAIL early_beat2: got v=%b d=%h err=%b, expected 1/33330000/1", drd_vout, drd_dout, err);
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL early_clr: got %b, expected 0", err); end
      tick(); tick(); tick();
   endtask

   task automatic test_enb_drop();
      int w;
      logic [31:0] exp;
      grant(32'h0000_010F, 32'h0000_5000, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL enb_grant: waited %0d, expected 1", w); end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = 32'h9900_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = 1'b0;
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp) begin
            errors++; $display("FAIL enb_beat%0d: got v=%b d=%h, expected 1/%h", i, drd_vout, drd_dout, exp);
         end
      end
      for (int i = 5; i < 7; i++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'h9900_0000 + 32'(i); enb = 1'b0;
         tick();
         checks++;
         if ({drd_vout, drd_dout, mem_arvalid, drd_ack} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL enb_off%0d: got v=%b d=%h arv=%b ack=%b, expected all 0", i, drd_vout, drd_dout, mem_arvalid, drd_ack);
         end
      end
      mem_rvalid = 1'b0; enb = 1'b1;
      grant(32'h0000_0101, 32'h0000_6000, w);
      checks++;
      if (w !== 1 || mem_arvalid !== 1'b1 || mem_arlen !== 8'h01 || mem_araddr !== 32'h0000_6000) begin
         errors++; $display("FAIL enb_regrant: waited %0d v=%b l=%h a=%h, expected 1/1/01/00006000", w, mem_arvalid, mem_arlen, mem_araddr);
      end
      mem_arready = 1'b1; tick(); mem_arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp = 32'h6600_0000 + 32'(i);
         mem_rvalid = 1'b1; mem_rdata = exp; mem_rlast = (i == 1);
         tick();
         checks++;
         if (drd_vout !== 1'b1 || drd_dout !== exp) begin
            errors++; $display("FAIL enb_new_beat%0d: got v=%b d=%h, expected 1/%h", i, drd_vout, drd_dout, exp);
         end
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0; drd_req = 1'b0;
      tick();
      checks++;
      if (err !== 1'b0 || frm_done !== 1'b0 || drd_vout !== 1'b0) begin
         errors++; $display("FAIL enb_end: got err=%b fd=%b v=%b, expected 0/0/0", err, frm_done, drd_vout);
      end
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_long_burst();
      test_frame_gaps();
      test_arready_stall();
      test_bad_header();
      test_early_rlast();
      test_enb_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
